// File: rtl/adc_frame_packer_if.sv
// adc_frame_packer_if: byte-stream valid/ready link from the frame packer to the UART sender
interface adc_frame_packer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  modport master(output tx_data, tx_valid, input tx_ready);
  modport slave(input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/adc_frame_packer.sv
// adc_frame_packer: captures periodic ADC bursts and streams them as checksummed byte frames
module adc_frame_packer #(
  parameter int CLK_FRE   = 50,
  parameter int SEND_FRE  = 2,
  parameter int BURST_LEN = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sample_en,
  input  logic [7:0]                ad9280_data,
  adc_frame_packer_if.master        tx,
  output logic                      busy,
  output logic                      frame_skip
);
  localparam int PERIOD = CLK_FRE * 1_000_000 / SEND_FRE;
  localparam int IW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  localparam logic [IW-1:0] LAST = IW'(BURST_LEN - 1);
  typedef enum logic [2:0] {IDLE, CAPTURE, HDR0, HDR1, SEQ, LEN, DATA, CSUM} state_t;
  state_t state, state_nx;
  logic [31:0] timer;
  logic tick, xfer, tx_state;
  logic [7:0] seq, csum, cur_byte;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [7:0] mem [BURST_LEN];
  assign tick = timer == 32'(PERIOD - 1);
  assign xfer = tx.tx_valid && tx.tx_ready;
  assign busy = state != IDLE;
  assign tx_state = busy && state != CAPTURE;
  always_comb begin
    cur_byte = state == HDR0 ? 8'hA5 :
               state == HDR1 ? 8'h5A :
               state == SEQ  ? seq :
               state == LEN  ? 8'(BURST_LEN) :
               state == DATA ? mem[rd_idx] : csum;
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (tick) state_nx = CAPTURE;
      CAPTURE: if (sample_en && wr_idx == LAST) state_nx = HDR0;
      DATA:    if (xfer && rd_idx == LAST) state_nx = CSUM;
      CSUM:    if (xfer) state_nx = IDLE;
      default: if (xfer) state_nx = state_t'(state + 3'd1);
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer       <= '0;
      seq         <= '0;
      csum        <= '0;
      wr_idx      <= '0;
      rd_idx      <= '0;
      tx.tx_data  <= '0;
      tx.tx_valid <= 1'b0;
      frame_skip  <= 1'b0;
    end else begin
      timer      <= tick ? '0 : timer + 32'd1;
      frame_skip <= tick && busy;
      if (state == IDLE && tick) begin
        wr_idx <= '0;
        rd_idx <= '0;
        csum   <= seq + 8'(BURST_LEN);
      end
      if (state == CAPTURE && sample_en) begin
        csum   <= csum + ad9280_data;
        wr_idx <= wr_idx + 1'b1;
      end
      // Each byte is loaded one cycle after entering its state or after the previous transfer
      if (tx_state && !tx.tx_valid) begin
        tx.tx_valid <= 1'b1;
        tx.tx_data  <= cur_byte;
      end else if (xfer) begin
        tx.tx_valid <= 1'b0;
      end
      if (state == DATA && xfer) rd_idx <= rd_idx + 1'b1;
      if (state == CSUM && xfer) seq <= seq + 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (state == CAPTURE && sample_en) mem[wr_idx] <= ad9280_data;
  end
endmodule

// File: tb/tb_adc_frame_packer.sv
// tb_adc_frame_packer: randomized scoreboard bench for adc_frame_packer
module tb_adc_frame_packer;
  localparam int P  = 1000;
  localparam int BL = 4;
  logic clk = 1'b0, rst_n = 1'b0, sample_en = 1'b0;
  logic [7:0] adc = '0;
  logic busy, frame_skip;
  adc_frame_packer_if bus();
  adc_frame_packer #(.CLK_FRE(1), .SEND_FRE(1000), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .ad9280_data(adc),
    .tx(bus.master), .busy(busy), .frame_skip(frame_skip)
  );
  always #5 clk = ~clk;
  typedef struct {logic [7:0] b; bit last;} exp_t;
  exp_t q[$];
  exp_t e;
  int tests = 0, fails = 0;
  logic [7:0] mseq = '0;
  int mt = 0;
  bit mbusy = 0, exp_skip = 0, prev_stall = 0;
  int skip_seen = 0, skip_exp = 0;
  logic [7:0] prev_data;
  logic [7:0] s[$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask
  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout/unexpected required none", name);
  endtask
  // Reference frame: header, seq, length, samples, then mod-256 sum of everything after the header
  function automatic void push_frame(input logic [7:0] d[$]);
    int sum = mseq + BL;
    q.push_back('{8'hA5, 1'b0});
    q.push_back('{8'h5A, 1'b0});
    q.push_back('{mseq, 1'b0});
    q.push_back('{8'(BL), 1'b0});
    foreach (d[i]) begin
      q.push_back('{d[i], 1'b0});
      sum += d[i];
    end
    q.push_back('{8'(sum % 256), 1'b1});
    mseq++;
  endfunction
  always @(negedge clk) begin
    if (!rst_n) begin
      mt = 0;
      mbusy = 0;
      exp_skip = 0;
      prev_stall = 0;
    end else begin
      if (frame_skip || exp_skip) check("frame_skip", frame_skip, exp_skip);
      skip_seen += int'(frame_skip);
      skip_exp += int'(exp_skip);
      if (prev_stall) begin
        check("hold_valid", bus.tx_valid, 1);
        check("hold_data", bus.tx_data, prev_data);
      end
      exp_skip = 0;
      if (mt == P - 1) begin
        if (mbusy) exp_skip = 1;
        else mbusy = 1;
        mt = 0;
      end else mt++;
      if (bus.tx_valid && bus.tx_ready) begin
        if (q.size() == 0) fail_now("spurious_byte");
        else begin
          e = q.pop_front();
          check("tx_byte", bus.tx_data, e.b);
          if (e.last) mbusy = 0;
        end
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data = bus.tx_data;
    end
  end
  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask
  task automatic begin_frame(input logic [7:0] d[$], input bit junk);
    int n = 0;
    while (!busy && n < 2 * P + 20) begin
      sample_en = junk && ($urandom % 4 == 0);
      adc = 8'($urandom);
      tick_clk();
      n++;
    end
    sample_en = 1'b0;
    if (!busy) begin
      fail_now("frame_start");
      return;
    end
    push_frame(d);
    foreach (d[i]) begin
      repeat ($urandom_range(0, 2)) tick_clk();
      sample_en = 1'b1;
      adc = d[i];
      tick_clk();
      sample_en = 1'b0;
      adc = 8'($urandom);
    end
  endtask
  task automatic end_frame(input bit rnd, input bit junk);
    int n = 0;
    while (busy && n < 4000) begin
      if (rnd) bus.tx_ready = ($urandom % 3) != 0;
      sample_en = junk && ($urandom % 4 == 0);
      adc = 8'($urandom);
      tick_clk();
      n++;
    end
    sample_en = 1'b0;
    bus.tx_ready = 1'b1;
    if (busy) fail_now("frame_end");
    repeat (2) tick_clk();
    check("frame_drained", q.size(), 0);
  endtask
  task automatic wait_byte(input logic [7:0] b);
    int n = 0;
    while (!(bus.tx_valid && bus.tx_data == b) && n < 200) begin
      tick_clk();
      n++;
    end
    if (n >= 200) fail_now("wait_byte");
  endtask
  task automatic rand_samples();
    s = {};
    repeat (BL) s.push_back(8'($urandom));
  endtask
  initial begin
    int sk0, se0;
    bus.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_skip", frame_skip, 0);
    rst_n = 1'b1;
    s = '{8'h10, 8'h20, 8'h30, 8'h40};
    begin_frame(s, 0);
    end_frame(0, 0);
    s = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    begin_frame(s, 0);
    end_frame(0, 0);
    repeat (3) begin
      rand_samples();
      begin_frame(s, 1);
      end_frame(1, 1);
    end
    s = '{8'h10, 8'h20, 8'h30, 8'h40};
    begin_frame(s, 0);
    wait_byte(8'h30);
    bus.tx_ready = 1'b0;
    repeat (50) tick_clk();
    check("bp_valid", bus.tx_valid, 1);
    check("bp_data", bus.tx_data, 8'h30);
    bus.tx_ready = 1'b1;
    end_frame(0, 0);
    sk0 = skip_seen;
    se0 = skip_exp;
    rand_samples();
    begin_frame(s, 0);
    bus.tx_ready = 1'b0;
    repeat (2500) tick_clk();
    bus.tx_ready = 1'b1;
    end_frame(0, 0);
    check("skip_count", skip_seen - sk0, skip_exp - se0);
    rand_samples();
    begin_frame(s, 1);
    end_frame(1, 1);
    s = '{8'hC3, 8'h11, 8'h22, 8'h33};
    begin_frame(s, 0);
    wait_byte(8'hC3);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_valid", bus.tx_valid, 0);
    check("mid_rst_busy", busy, 0);
    q.delete();
    mseq = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rand_samples();
    begin_frame(s, 0);
    end_frame(0, 0);
    check("final_queue", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
